// File: rtl/stopwatch_controller_if.sv
// Button/step/switch inputs and tick/mode outputs exchanged between the
// stopwatch sequencer and its surroundings.
interface stopwatch_controller_if;
  localparam int unsigned SPEED_W = 5;
  localparam int unsigned MODE_W  = 3;

  logic               btn_reset_i;
  logic               btn_stop_i;
  logic               btn_up_i;
  logic               btn_down_i;
  logic               ext_step_i;
  logic               clk_sel_i;
  logic [SPEED_W-1:0] speed_i;
  logic               at_zero_i;
  logic               tick_o;
  logic               dir_o;
  logic               clear_count_o;
  logic [MODE_W-1:0]  mode_output_o;
  logic               clk_output_o;

  modport slave (
    input  btn_reset_i, btn_stop_i, btn_up_i, btn_down_i, ext_step_i,
           clk_sel_i, speed_i, at_zero_i,
    output tick_o, dir_o, clear_count_o, mode_output_o, clk_output_o
  );

  modport master (
    output btn_reset_i, btn_stop_i, btn_up_i, btn_down_i, ext_step_i,
           clk_sel_i, speed_i, at_zero_i,
    input  tick_o, dir_o, clear_count_o, mode_output_o, clk_output_o
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch command sequencer: button edge detection, mode FSM, prescaled or
// external tick generation, direction and clear control for the datapath.
module stopwatch_controller #(
  parameter int unsigned PRESCALE_BASE = 50000,
  parameter int unsigned PRESC_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stopwatch_controller_if.slave  bus
);
  localparam int unsigned NBTN   = 5;
  localparam int unsigned B_RST  = 0;
  localparam int unsigned B_STOP = 1;
  localparam int unsigned B_UP   = 2;
  localparam int unsigned B_DOWN = 3;
  localparam int unsigned B_EXT  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    RUN_UP   = 3'b001,
    RUN_DOWN = 3'b010,
    PAUSED   = 3'b100,
    DONE     = 3'b110
  } state_e;

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic                tick_q, tick_d;
  logic                clear_q, clear_d;
  logic                clk_out_q, clk_out_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  period_m1;
  logic [NBTN-1:0]     prev_q, lvl, press;
  logic                run, due, tick_ok;

  assign lvl = {bus.ext_step_i, bus.btn_down_i, bus.btn_up_i, bus.btn_stop_i, bus.btn_reset_i};
  assign press = lvl & ~prev_q;
  assign period_m1 = PRESC_W'(PRESCALE_BASE) * (PRESC_W'(bus.speed_i) + PRESC_W'(1))
                     - PRESC_W'(1);

  // Prev registers start high so a level held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dir_q     <= 1'b1;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      clk_out_q <= 1'b0;
      presc_q   <= '0;
      prev_q    <= '1;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      clk_out_q <= clk_out_d;
      presc_q   <= presc_d;
      prev_q    <= lvl;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    clear_d   = 1'b0;
    clk_out_d = clk_out_q;
    due       = 1'b0;
    tick_ok   = 1'b1;
    run       = (state_q == RUN_UP) || (state_q == RUN_DOWN);

    // Tick source; >= lets a lowered speed take effect without wrapping
    if (bus.clk_sel_i) begin
      presc_d = '0;
      due     = run & press[B_EXT];
    end else if (run) begin
      if (presc_q >= period_m1) begin
        presc_d = '0;
        due     = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end else if (state_q != PAUSED) begin
      presc_d = '0;
    end

    // Only the highest-priority press acts, even when it is ignored
    if (press[B_RST]) begin
      state_d = IDLE;
      dir_d   = 1'b1;
      clear_d = 1'b1;
      presc_d = '0;
      tick_ok = 1'b0;
    end else if (press[B_STOP]) begin
      if (run) begin
        state_d = PAUSED;
        tick_ok = 1'b0;
      end else if (state_q == PAUSED) begin
        state_d = dir_q ? RUN_UP : RUN_DOWN;
      end
    end else if (press[B_UP]) begin
      if (state_q != RUN_UP) begin
        state_d = RUN_UP;
        dir_d   = 1'b1;
      end
    end else if (press[B_DOWN]) begin
      if (state_q inside {IDLE, PAUSED, RUN_UP}) begin
        state_d = RUN_DOWN;
        dir_d   = 1'b0;
      end
    end

    // Counting down past zero is replaced by the DONE transition
    if (due && tick_ok) begin
      if ((state_q == RUN_DOWN) && (state_d == RUN_DOWN) && bus.at_zero_i) begin
        state_d = DONE;
      end else begin
        tick_d = 1'b1;
      end
    end

    clk_out_d = clk_out_q ^ tick_d;
  end

  assign bus.tick_o        = tick_q;
  assign bus.dir_o         = dir_q;
  assign bus.clear_count_o = clear_q;
  assign bus.mode_output_o = state_q;
  assign bus.clk_output_o  = clk_out_q;
endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Command sequencer for the stopwatch counting datapath. Turns the four debounced button levels, the external step input and the clock-select/speed switches into a mode state machine, a count-enable tick stream, a direction bit and a clear pulse. Sits between the Debouncer instances and the stopwatch datapath, and owns all start/stop/direction sequencing so the datapath only counts on `Tick`.

## Interface
- `PRESCALE_BASE`, default 50000: `Clk` cycles per internal tick at `Speed`=0.
- `PRESC_W`, default 32: prescaler counter width; must hold `PRESCALE_BASE`*32.
- `Clk`  in  1  system clock; all state is on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `BtnReset`, `BtnStop`, `BtnUp`, `BtnDown`  in  1 each  debounced button levels, active-high.
- `ExtStep`  in  1  debounced external step level, active-high.
- `ClkSel`  in  1  tick source: 0 = internal prescaler, 1 = `ExtStep` edges.
- `Speed`  in  5  prescale multiplier select; period = `PRESCALE_BASE`*(`Speed`+1).
- `AtZero`  in  1  from datapath: count value is 0.
- `Tick`  out  1  one-cycle count enable to the datapath.
- `Dir`  out  1  count direction: 1 = up, 0 = down.
- `ClearCount`  out  1  one-cycle pulse: datapath clears its count.
- `ModeOutput`  out  3  state indication for the LEDs.
- `ClkOutput`  out  1  toggles on every `Tick`.

## Operation
- Edge detect: each button and `ExtStep` has a previous-level register. Press = level & ~prev. Prev registers reset to 1, so a button held through reset release is not a press.
- Priority among presses in the same cycle: Reset > Stop > Up > Down. Only the highest press acts; the rest are dropped.
- States and `ModeOutput`: IDLE 000, RUN_UP 001, RUN_DOWN 010, PAUSED 100, DONE 110.
- Reset press, from any state: go to IDLE, pulse `ClearCount`, clear the prescaler, set `Dir`=1.
- Up press: go from IDLE, PAUSED, RUN_DOWN or DONE to RUN_UP with `Dir`=1. Ignored in RUN_UP.
- Down press: go from IDLE, PAUSED or RUN_UP to RUN_DOWN with `Dir`=0. Ignored in RUN_DOWN and DONE.
- Stop press:
  - RUN_UP or RUN_DOWN go to PAUSED; `Dir` is kept.
  - PAUSED resumes RUN_UP if `Dir`=1, RUN_DOWN if `Dir`=0.
  - Ignored in IDLE and DONE.
- Prescaler (`ClkSel`=0):
  - Increments only in RUN_UP or RUN_DOWN; holds in PAUSED; cleared in IDLE and DONE.
  - When count >= period-1, it returns to 0 and a tick is due.
  - The `>=` compare means a lower `Speed` written mid-count takes effect at once, with no wrap-around.
  - Direction changes (RUN_UP to RUN_DOWN and back) do not clear it.
- External source (`ClkSel`=1): the prescaler is held at 0; a tick is due on each `ExtStep` press in a run state. A held level gives exactly one tick.
- Tick gating: in RUN_DOWN with `AtZero`=1, a due tick is suppressed and the FSM goes to DONE. A tick due in any non-run state is discarded.
- `ClkOutput` toggles on every asserted `Tick`.

## Timing
- Async reset: state IDLE, `Tick`=0, `ClearCount`=0, `Dir`=1, `ModeOutput`=000, `ClkOutput`=0, prescaler=0, prev registers=1.
- Reset assertion mid-run takes effect immediately, without `Clk`. `ClearCount` is not pulsed by async reset.
- Press latency: the state, `Dir`, `ModeOutput` and `ClearCount` change at the first `Clk` edge where level=1 and prev=0.
- Tick latency:
  - `Tick` is registered and high for the cycle after the edge where the prescaler reaches period-1.
  - On entering a run state from a cleared prescaler, the first `Tick` comes exactly period cycles later, then every period cycles.
  - In external mode, `Tick` is high one cycle after the press edge.
- The DONE transition and the suppressed tick occur on the same edge; `Tick` stays 0.
- A Stop press on the same edge a tick falls due: PAUSED wins and `Tick` stays 0. The prescaler holds at 0, so after resume the next `Tick` comes one full period later.

## Test plan
- Async reset pulse mid-RUN_UP with `PRESCALE_BASE`=4 -> all outputs at reset values at once; `ClearCount` stays 0; a held `BtnUp` after release gives no transition.
- `PRESCALE_BASE`=4, `Speed`=2, Up press -> `ModeOutput`=001, `Dir`=1; `Tick` pulses every 12 cycles, first at 12 cycles after entry; `ClkOutput` toggles on each.
- RUN_UP, Stop press 5 cycles after a `Tick` -> PAUSED (100), no `Tick` during a 40-cycle pause; Stop again -> RUN_UP, next `Tick` 7 cycles later.
- Speed drops from 31 to 0 mid-count with prescaler at 50 and `PRESCALE_BASE`=4 -> `Tick` on the next cycle, then every 4 cycles.
- RUN_DOWN with `AtZero`=1 -> on the next due tick `Tick` stays 0 and `ModeOutput`=110; Down press ignored; Up press -> 001.
- Simultaneous Reset+Up presses in RUN_DOWN -> IDLE (000), one-cycle `ClearCount`, `Dir`=1. `ClkSel`=1 with `ExtStep` held 20 cycles in RUN_UP -> exactly one `Tick`.
